// File: rtl/disp_sr_mc.sv
// Multi-chain display shift-register driver: snapshots a packed image per frame,
// shifts N_CHAIN serial chains on a shared sclk, latches, and PWM-drives oe_n.
module disp_sr_mc #(
  parameter int DATA_W    = 64,
  parameter int N_CHAIN   = 4,
  parameter int SCLK_DIV  = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tsc_1ppms,
  input  logic                        tsc_1ppus,
  input  logic [N_CHAIN*DATA_W-1:0]   disp_data,
  input  logic [7:0]                  disp_bright,
  output logic                        disp_sclk,
  output logic                        disp_lat,
  output logic [N_CHAIN-1:0]          disp_sin,
  output logic                        disp_oe_n,
  output logic                        busy,
  output logic                        overrun
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t                      state_r, state_s;
  logic [DIV_W-1:0]            div_cnt_r, div_cnt_s;
  logic [IDX_W-1:0]            idx_r, idx_s;
  logic [N_CHAIN*DATA_W-1:0]   shadow_r, shadow_s;
  logic                        pending_r, pending_s;
  logic                        overrun_s;
  logic                        phase_done_s;
  logic [IDX_W-1:0]            bit_pos_s;
  logic [DATA_W-1:0]           chain_s [N_CHAIN];
  logic [N_CHAIN-1:0]          sin_s;
  logic [7:0]                  pwm_cnt_r;

  logic                        sclk_r, lat_r, oe_n_r, busy_r, overrun_r;
  logic [N_CHAIN-1:0]          sin_r;

  assign phase_done_s = (div_cnt_r == DIV_LAST);

  // Frame sequencer next-state: phase counter, bit index and image snapshot
  always_comb begin
    state_s   = state_r;
    div_cnt_s = div_cnt_r;
    idx_s     = idx_r;
    shadow_s  = shadow_r;
    case (state_r)
      IDLE: begin
        div_cnt_s = '0;
        if (pending_r || tsc_1ppms) begin
          state_s  = SHIFT_LO;
          shadow_s = disp_data;
          idx_s    = '0;
        end else begin
          state_s  = IDLE;
        end
      end
      SHIFT_LO: begin
        if (phase_done_s) begin
          state_s   = SHIFT_HI;
          div_cnt_s = '0;
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_done_s) begin
          div_cnt_s = '0;
          if (idx_r == IDX_LAST) begin
            state_s = LATCH;
          end else begin
            state_s = SHIFT_LO;
            idx_s   = idx_r + IDX_W'(1);
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      LATCH: begin
        if (phase_done_s) begin
          state_s   = IDLE;
          div_cnt_s = '0;
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_s   = IDLE;
        div_cnt_s = '0;
        idx_s     = '0;
      end
    endcase
  end

  // Trigger queueing: one trigger may wait behind a frame; a second one is dropped
  always_comb begin
    pending_s = pending_r;
    overrun_s = 1'b0;
    if (state_r == IDLE) begin
      pending_s = 1'b0;
      overrun_s = pending_r & tsc_1ppms;
    end else if (tsc_1ppms) begin
      if (pending_r) begin
        overrun_s = 1'b1;
      end else begin
        pending_s = 1'b1;
      end
    end else begin
      pending_s = pending_r;
    end
  end

  // Serial data for the upcoming cycle, taken from the next-state snapshot
  always_comb begin
    bit_pos_s = (MSB_FIRST != 0) ? (IDX_LAST - idx_s) : idx_s;
    sin_s     = '0;
    for (int c = 0; c < N_CHAIN; c++) begin
      chain_s[c] = shadow_s[c*DATA_W +: DATA_W];
      if ((state_s == SHIFT_LO) || (state_s == SHIFT_HI)) begin
        sin_s[c] = chain_s[c][bit_pos_s];
      end else begin
        sin_s[c] = 1'b0;
      end
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      div_cnt_r <= '0;
      idx_r     <= '0;
      shadow_r  <= '0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_cnt_r <= div_cnt_s;
      idx_r     <= idx_s;
      shadow_r  <= shadow_s;
      pending_r <= pending_s;
    end
  end

  // PWM step counter, free-running on the microsecond tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_r <= 8'd0;
    end else if (tsc_1ppus) begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

  // Registered pin drivers; oe_n blanks on the same cycles the latch is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_r    <= 1'b0;
      lat_r     <= 1'b0;
      sin_r     <= '0;
      oe_n_r    <= 1'b1;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      sclk_r    <= (state_s == SHIFT_HI);
      lat_r     <= (state_s == LATCH);
      sin_r     <= sin_s;
      oe_n_r    <= !(pwm_cnt_r < disp_bright) || (state_s == LATCH);
      busy_r    <= (state_s != IDLE);
      overrun_r <= overrun_s;
    end
  end

  assign disp_sclk = sclk_r;
  assign disp_lat  = lat_r;
  assign disp_sin  = sin_r;
  assign disp_oe_n = oe_n_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_disp_sr_mc.sv
// Bench for disp_sr_mc: default 4x64 MSB-first instance plus an 8-bit LSB-first
// instance, checked against frame-level expectations computed from the image words.
module tb_disp_sr_mc;

  localparam int DW        = 64;
  localparam int NC        = 4;
  localparam int SD        = 4;
  localparam int FRAME_CYC = 2*SD*DW + SD;
  localparam int SD8       = 2;
  localparam int FRAME8    = 2*SD8*8 + SD8;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic             rst, ms, us;
  logic [NC*DW-1:0] data;
  logic [7:0]       bright;
  logic             sclk, lat, oe_n, busy, ovr;
  logic [NC-1:0]    sin;

  logic             ms8, us8;
  logic [7:0]       data8, bright8;
  logic             sclk8, lat8, oe8, busy8, ovr8;
  logic [0:0]       sin8;

  disp_sr_mc dut (
    .clk(clk), .rst(rst), .tsc_1ppms(ms), .tsc_1ppus(us),
    .disp_data(data), .disp_bright(bright),
    .disp_sclk(sclk), .disp_lat(lat), .disp_sin(sin),
    .disp_oe_n(oe_n), .busy(busy), .overrun(ovr)
  );

  disp_sr_mc #(.DATA_W(8), .N_CHAIN(1), .SCLK_DIV(SD8), .MSB_FIRST(0)) dut8 (
    .clk(clk), .rst(rst), .tsc_1ppms(ms8), .tsc_1ppus(us8),
    .disp_data(data8), .disp_bright(bright8),
    .disp_sclk(sclk8), .disp_lat(lat8), .disp_sin(sin8),
    .disp_oe_n(oe8), .busy(busy8), .overrun(ovr8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] cap [NC];
  int  n_rise, n_lat, n_busy, n_ovr, n_oe_bad, first_busy;
  bit  timed_out;

  task automatic fire();
    @(negedge clk);
    ms = 1'b1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NC*DW/32; i++) data[i*32 +: 32] = $urandom();
  endtask

  // Observe one frame; extra triggers fire at busy-cycle indices t1/t2.
  task automatic capture(input int t1, input int t2, input bit scramble);
    logic prev;
    prev = 1'b0;
    n_rise = 0; n_lat = 0; n_busy = 0; n_ovr = 0; n_oe_bad = 0;
    first_busy = -1; timed_out = 1'b1;
    for (int c = 0; c < NC; c++) cap[c] = '0;
    for (int it = 0; it < 2000; it++) begin
      @(negedge clk);
      ms = 1'b0;
      if (scramble && it == 10) rand_data();
      if (busy) begin
        if (first_busy < 0) first_busy = it;
        if (n_busy == t1 || n_busy == t2) ms = 1'b1;
        n_busy++;
      end else if (first_busy >= 0) begin
        timed_out = 1'b0;
        break;
      end
      if (sclk && !prev) begin
        n_rise++;
        for (int c = 0; c < NC; c++) cap[c] = {cap[c][DW-2:0], sin[c]};
      end
      prev = sclk;
      if (lat) begin
        n_lat++;
        if (!oe_n) n_oe_bad++;
      end
      if (ovr) n_ovr++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ms = 1'b0; us = 1'b0; data = '0; bright = 8'd0;
    ms8 = 1'b0; us8 = 1'b0; data8 = 8'd0; bright8 = 8'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({sclk, lat, sin, oe_n, busy, ovr} !== 9'b000000100) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", {sclk, lat, sin, oe_n, busy, ovr}, 9'b000000100);
    end
    n_tests++;
    if ({sclk8, lat8, sin8, oe8, busy8, ovr8} !== 6'b000100) begin
      n_fail++;
      $display("FAIL reset_outputs8: got %b want %b", {sclk8, lat8, sin8, oe8, busy8, ovr8}, 6'b000100);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] w;
    w = 64'h5aaa_aaaa_aaaa_aaa5;
    data = '0;
    data[0 +: DW] = w;
    bright = 8'd255;
    fire();
    capture(-1, -1, 1'b0);
    n_tests++;
    if (timed_out || first_busy !== 0) begin
      n_fail++;
      $display("FAIL single_start: timed_out=%0d first_busy=%0d want 0", timed_out, first_busy);
    end
    n_tests++;
    if (n_busy !== FRAME_CYC) begin
      n_fail++;
      $display("FAIL single_busy_len: got %0d want %0d", n_busy, FRAME_CYC);
    end
    n_tests++;
    if (n_lat !== SD) begin
      n_fail++;
      $display("FAIL single_lat_len: got %0d want %0d", n_lat, SD);
    end
    n_tests++;
    if (n_rise !== DW) begin
      n_fail++;
      $display("FAIL single_sclk_edges: got %0d want %0d", n_rise, DW);
    end
    n_tests++;
    if (cap[0] !== w) begin
      n_fail++;
      $display("FAIL single_chain0: got %h want %h", cap[0], w);
    end
    for (int c = 1; c < NC; c++) begin
      n_tests++;
      if (cap[c] !== '0) begin
        n_fail++;
        $display("FAIL single_chain%0d_quiet: got %h want 0", c, cap[c]);
      end
    end
    n_tests++;
    if (n_oe_bad !== 0 || n_ovr !== 0) begin
      n_fail++;
      $display("FAIL single_oe_ovr: oe_low_in_lat=%0d overruns=%0d want 0/0", n_oe_bad, n_ovr);
    end
  endtask

  task automatic test_crosstalk();
    logic [DW-1:0] pat [NC];
    pat[0] = 64'ha5a5_a5a5_a5a5_a5a5;
    pat[1] = 64'h5a5a_5a5a_5a5a_5a5a;
    pat[2] = 64'hffff_ffff_ffff_ffff;
    pat[3] = 64'h0000_0000_0000_0000;
    for (int c = 0; c < NC; c++) data[c*DW +: DW] = pat[c];
    fire();
    capture(-1, -1, 1'b0);
    for (int c = 0; c < NC; c++) begin
      n_tests++;
      if (cap[c] !== pat[c]) begin
        n_fail++;
        $display("FAIL xtalk_chain%0d: got %h want %h", c, cap[c], pat[c]);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [NC*DW-1:0] exp;
    for (int r = 0; r < 3; r++) begin
      rand_data();
      exp = data;
      fire();
      capture(-1, -1, 1'b1);
      for (int c = 0; c < NC; c++) begin
        n_tests++;
        if (cap[c] !== exp[c*DW +: DW]) begin
          n_fail++;
          $display("FAIL rand%0d_chain%0d: got %h want %h", r, c, cap[c], exp[c*DW +: DW]);
        end
      end
      n_tests++;
      if (n_busy !== FRAME_CYC || n_lat !== SD) begin
        n_fail++;
        $display("FAIL rand%0d_timing: busy=%0d lat=%0d want %0d/%0d", r, n_busy, n_lat, FRAME_CYC, SD);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NC*DW-1:0] exp1, exp2;
    rand_data();
    exp1 = data;
    fire();
    capture(100, 300, 1'b1);
    exp2 = data;
    for (int c = 0; c < NC; c++) begin
      n_tests++;
      if (cap[c] !== exp1[c*DW +: DW]) begin
        n_fail++;
        $display("FAIL b2b_f1_chain%0d: got %h want %h", c, cap[c], exp1[c*DW +: DW]);
      end
    end
    n_tests++;
    if (n_ovr !== 1) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %0d pulses want 1", n_ovr);
    end
    capture(-1, -1, 1'b0);
    n_tests++;
    if (timed_out || first_busy !== 0 || n_busy !== FRAME_CYC) begin
      n_fail++;
      $display("FAIL b2b_f2_start: timed_out=%0d first_busy=%0d busy=%0d want 0/0/%0d", timed_out, first_busy, n_busy, FRAME_CYC);
    end
    for (int c = 0; c < NC; c++) begin
      n_tests++;
      if (cap[c] !== exp2[c*DW +: DW]) begin
        n_fail++;
        $display("FAIL b2b_f2_chain%0d: got %h want %h", c, cap[c], exp2[c*DW +: DW]);
      end
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_extra_frame: busy=%b want 0", busy);
    end
    rand_data();
    exp1 = data;
    fire();
    capture(FRAME_CYC - 1, -1, 1'b0);
    n_tests++;
    if (timed_out || first_busy !== 0 || n_ovr !== 0 || cap[1] !== exp1[DW +: DW]) begin
      n_fail++;
      $display("FAIL third_frame: first_busy=%0d ovr=%0d chain1=%h want 0/0/%h", first_busy, n_ovr, cap[1], exp1[DW +: DW]);
    end
    capture(-1, -1, 1'b0);
    n_tests++;
    if (timed_out || first_busy !== 0 || n_busy !== FRAME_CYC || n_ovr !== 0) begin
      n_fail++;
      $display("FAIL edge_trig_frame: first_busy=%0d busy=%0d ovr=%0d want 0/%0d/0", first_busy, n_busy, n_ovr, FRAME_CYC);
    end
    n_tests++;
    if (cap[3] !== exp1[3*DW +: DW]) begin
      n_fail++;
      $display("FAIL edge_trig_chain3: got %h want %h", cap[3], exp1[3*DW +: DW]);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_pwm();
    logic [7:0] levels [4];
    int cnt;
    levels[0] = 8'd64;
    levels[1] = 8'd0;
    levels[2] = 8'd255;
    levels[3] = 8'($urandom_range(1, 254));
    for (int l = 0; l < 4; l++) begin
      bright = levels[l];
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        us = ((k % 2) == 0);
      end
      cnt = 0;
      for (int k = 0; k < 512; k++) begin
        @(negedge clk);
        us = ((k % 2) == 0);
        if (!oe_n) cnt++;
      end
      n_tests++;
      if (cnt !== 2 * int'(levels[l])) begin
        n_fail++;
        $display("FAIL pwm_bright%0d: oe_n low %0d cycles want %0d", levels[l], cnt, 2 * int'(levels[l]));
      end
    end
    @(negedge clk);
    us = 1'b0;
    bright = 8'd255;
  endtask

  task automatic test_reset_midframe();
    logic [NC*DW-1:0] exp;
    logic prev;
    int rises;
    bit hit;
    rand_data();
    fire();
    prev = 1'b0; rises = 0; hit = 1'b0;
    for (int it = 0; it < 1000; it++) begin
      @(negedge clk);
      ms = (it == 40);
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises == 30) begin
        hit = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_mid_reach: got %0d edges want 30", rises);
    end
    ms = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({sclk, lat, sin, oe_n, busy, ovr} !== 9'b000000100) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b want %b", {sclk, lat, sin, oe_n, busy, ovr}, 9'b000000100);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pending_cleared: busy=%b want 0", busy);
    end
    rand_data();
    exp = data;
    fire();
    capture(-1, -1, 1'b0);
    n_tests++;
    if (timed_out || n_busy !== FRAME_CYC || n_lat !== SD || n_rise !== DW) begin
      n_fail++;
      $display("FAIL rst_clean_frame: busy=%0d lat=%0d edges=%0d want %0d/%0d/%0d", n_busy, n_lat, n_rise, FRAME_CYC, SD, DW);
    end
    for (int c = 0; c < NC; c++) begin
      n_tests++;
      if (cap[c] !== exp[c*DW +: DW]) begin
        n_fail++;
        $display("FAIL rst_clean_chain%0d: got %h want %h", c, cap[c], exp[c*DW +: DW]);
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w, c8;
    logic prev, first;
    int rises, nb;
    bit seen, done;
    for (int r = 0; r < 4; r++) begin
      w = (r == 0) ? 8'h01 : 8'($urandom());
      data8 = w;
      @(negedge clk);
      ms8 = 1'b1;
      prev = 1'b0; first = 1'b0; rises = 0; nb = 0; seen = 1'b0; done = 1'b0; c8 = 8'd0;
      for (int it = 0; it < 200; it++) begin
        @(negedge clk);
        ms8 = 1'b0;
        if (busy8) begin
          seen = 1'b1;
          nb++;
        end else if (seen) begin
          done = 1'b1;
          break;
        end
        if (sclk8 && !prev) begin
          if (rises == 0) first = sin8[0];
          rises++;
          c8 = {sin8[0], c8[7:1]};
        end
        prev = sclk8;
      end
      n_tests++;
      if (!done || c8 !== w || rises !== 8 || nb !== FRAME8) begin
        n_fail++;
        $display("FAIL lsb%0d: done=%0d word=%h edges=%0d busy=%0d want 1/%h/8/%0d", r, done, c8, rises, nb, w, FRAME8);
      end
      if (r == 0) begin
        n_tests++;
        if (first !== 1'b1) begin
          n_fail++;
          $display("FAIL lsb_first_bit: got %b want 1", first);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_crosstalk();
    test_random_frames();
    test_back_to_back();
    test_pwm();
    test_reset_midframe();
    test_lsb_first();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_sr_mc.md
Name: disp_sr_mc

Overview:
Multi-chain, parametrised display shift-register driver. It is the successor to the single-chain 256-bit display driver. On a frame trigger it snapshots a packed display image and shifts N_CHAIN serial chains in parallel on a shared sclk, then pulses a shared latch. It also adds PWM brightness via an active-low output-enable. It sits between the clock/display formatter and the off-chip LED driver shift registers, timed by the tsc_1ppms/tsc_1ppus ticks.

Parameters:
DATA_W, 64, bits per chain (>=2)
N_CHAIN, 4, number of parallel serial chains (>=1)
SCLK_DIV, 4, clk cycles per sclk half-period (>=1)
MSB_FIRST, 1, 1 = shift bit DATA_W-1 first; 0 = bit 0 first

Ports:
clk  in  1  system clock (200 MHz nominal)
rst  in  1  asynchronous active-high reset
tsc_1ppms  in  1  one-clk frame trigger pulse
tsc_1ppus  in  1  one-clk PWM step pulse
disp_data  in  N_CHAIN*DATA_W  packed image; chain c = disp_data[c*DATA_W +: DATA_W]
disp_bright  in  8  brightness duty, 0..255
disp_sclk  out  1  shared shift clock
disp_lat  out  1  shared latch strobe
disp_sin  out  N_CHAIN  serial data, one bit per chain
disp_oe_n  out  1  active-low output enable (PWM)
busy  out  1  frame transfer in progress
overrun  out  1  one-clk pulse when a trigger is dropped

Behaviour:
- Reset (async assert, sync release): disp_sclk=0, disp_lat=0, disp_sin=0, disp_oe_n=1, busy=0, overrun=0, state IDLE, pending=0, pwm_cnt=0.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: tsc_1ppms sampled high at edge t -> at t+1: snapshot disp_data into shadow, bit index=0, state SHIFT_LO, busy=1.
- SHIFT_LO: sclk=0; disp_sin[c] = shadow chain c bit (MSB_FIRST ? DATA_W-1-idx : idx), stable for the whole phase; lasts SCLK_DIV cycles -> SHIFT_HI.
- SHIFT_HI: sclk=1 and disp_sin held; lasts SCLK_DIV cycles. If idx<DATA_W-1: idx++ -> SHIFT_LO; else -> LATCH.
- LATCH: sclk=0, disp_lat=1 for SCLK_DIV cycles -> IDLE; lat=0 and busy=0 on entry to IDLE.
- Frame length: 2*SCLK_DIV*DATA_W + SCLK_DIV cycles (defaults: 516).
- disp_sin returns to 0 in LATCH and IDLE.
- Trigger while busy: first trigger sets pending. The new frame starts the cycle after IDLE is re-entered, snapshotting disp_data at that time. Any further trigger while pending=1 is dropped -> overrun=1 for one cycle.
- Trigger on the same cycle the block returns to IDLE counts as busy (pending path); there is no lost cycle beyond one IDLE cycle.
- disp_data changes mid-frame have no effect on the current frame (shadow only).
- PWM: pwm_cnt (8 bit) increments on tsc_1ppus and wraps 255->0.
- disp_oe_n = !(pwm_cnt < disp_bright) || disp_lat, registered (1-cycle latency). disp_bright=0 -> always 1; disp_bright=255 -> low 255 of every 256 steps.
- Reset mid-frame: outputs return to reset values immediately, the frame is abandoned, and pending is cleared. There is no partial latch.

Test Plan:
- Defaults, N_CHAIN=4, chain0=64'h5aaa_aaaa_aaaa_aaa5, others 0, single tsc_1ppms -> chain0 sin on 64 rising sclk edges reproduces the word MSB first; 64 rising edges; lat high exactly 4 cycles; busy high 516 cycles.
- MSB_FIRST=0, DATA_W=8, chain=8'h01 -> first sampled bit 1, remaining 7 bits 0.
- Distinct per-chain patterns (a5.., 5a.., all-1, all-0) -> each disp_sin[c] carries only its own slice; no crosstalk.
- Two triggers during a frame -> second-frame start immediately after the first ends, one overrun pulse for the second extra trigger; a third trigger after idle starts normally.
- disp_bright=64 with tsc_1ppus every 2 clk -> disp_oe_n low for 64 of every 256 ticks. Forced high while disp_lat=1. bright=0 -> constant 1.
- Assert rst at bit 30 of a frame -> sclk/lat/sin=0, oe_n=1, busy=0 within the same cycle; next trigger yields a full clean frame.
